// File: rtl/id_ex_skid_pkg.sv
// Shared constants for the ID/EX stage. These are the NOP bubble values
// that decode and execute already agree on.
package id_ex_skid_pkg;

    localparam logic [7:0]  EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP = 3'b000;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/id_ex_skid_buf.sv
// Generic two-entry skid buffer over a packed payload.
// The main register drives the output directly. The skid register holds
// the one beat that may arrive in the cycle the consumer stalls.
// Both in_ready and out_valid are registered. They are pure functions of
// the state.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | main holds the NOP value, nothing valid
// ONE   | main holds a valid beat, skid empty
// TWO   | main and skid both valid, upstream stalled
module pipe_skid_buf
    import id_ex_skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] nop_val,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    // State, storage and registered handshake outputs. Reset and flush share one path.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state     <= EMPTY;
            main_q    <= nop_val;
            skid_q    <= nop_val;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end else if (out_fire) begin
                        main_q    <= nop_val;
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    // Upstream is stalled here, so the skid beat is the only successor.
                    if (out_fire) begin
                        main_q   <= skid_q;
                        skid_q   <= nop_val;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_q    <= nop_val;
                    skid_q    <= nop_val;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline stage with a valid/ready handshake and a two-entry skid.
// It packs the decode fields into one payload and supplies the NOP bubble.
// It also counts the cycles in which execute sees no valid beat.
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_data1,
    input  logic [DATA_W-1:0]   id_data2,
    input  logic [ADDR_W-1:0]   id_waddr,
    input  logic                id_we,
    input  logic                id_in_delayslot,
    input  logic                flush,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_data1,
    output logic [DATA_W-1:0]   ex_data2,
    output logic [ADDR_W-1:0]   ex_waddr,
    output logic                ex_we,
    output logic                ex_in_delayslot,
    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam int PW = ALUOP_W + ALUSEL_W + 2 * DATA_W + ADDR_W + 2;

    logic [PW-1:0] id_pl;
    logic [PW-1:0] ex_pl;
    logic [PW-1:0] nop_pl;

    assign id_pl  = {id_aluop, id_alusel, id_data1, id_data2, id_waddr, id_we, id_in_delayslot};
    assign nop_pl = {ALUOP_W'(EXE_NOP_OP), ALUSEL_W'(EXE_RES_NOP), DATA_W'(ZeroWord),
                     DATA_W'(ZeroWord), {ADDR_W{1'b0}}, 1'b0, 1'b0};

    assign {ex_aluop, ex_alusel, ex_data1, ex_data2, ex_waddr, ex_we, ex_in_delayslot} = ex_pl;

    pipe_skid_buf #(
        .W(PW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .nop_val  (nop_pl),
        .in_valid (id_valid),
        .in_ready (id_ready),
        .in_data  (id_pl),
        .out_valid(ex_valid),
        .out_ready(ex_ready),
        .out_data (ex_pl)
    );

    // Saturating bubble counter. Flush does not clear it, so it keeps the stall history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (!ex_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
